piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in/serial-out serializer: the transmit end of the serial link whose receive end is `sipo_shift_reg`. It accepts a `WIDTH`-bit word over a valid/ready handshake and shifts it out one bit per clock. It drives a qualifying enable so that a downstream `sipo_shift_reg` (`serial_in` ← `serial_out`, `en` ← `serial_en`) reassembles the word after `WIDTH` enabled edges. It supports gapless back-to-back words.

## Interface
- `WIDTH`, default 4: word width in bits, must be ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit `WIDTH-1` first, matching a left-shifting SIPO; 0 sends bit 0 first.
- `clk` in, 1: single clock; all state changes on its rising edge.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `in_valid` in, 1: `parallel_in` holds a word to send.
- `in_ready` out, 1: block accepts a word this cycle.
- `parallel_in` in, `WIDTH`: word to serialize; sampled only on handshake.
- `serial_out` out, 1: current serial bit.
- `serial_en` out, 1: high while `serial_out` carries a valid bit; the receiver captures on the next rising edge.
- `done` out, 1: high during the cycle the final bit of a word is driven.

## Operation
- Handshake: a word is accepted on a rising edge where `in_valid && in_ready`. `parallel_in` is copied into the internal shift register and the bit counter is loaded.
- FSM states:
  - `IDLE`: `serial_en`=0, `serial_out`=0, `in_ready`=1. On accept, go to `SHIFT`.
  - `SHIFT`: one bit is presented per cycle, `serial_en`=1. The counter decrements each edge.
  - On the last bit cycle, if a word is accepted, stay in `SHIFT` and reload. Otherwise return to `IDLE`.
- `in_ready` = (state==`IDLE`) || (state==`SHIFT` && last bit cycle). It is combinational from registered state only, with no combinational path from `in_valid`.
- Bit order:
  - `MSB_FIRST`=1: `serial_out` = `shreg[WIDTH-1]`, and `shreg` shifts left, filling with 0.
  - `MSB_FIRST`=0: `serial_out` = `shreg[0]`, and `shreg` shifts right.
- Counter width: `$clog2(WIDTH+1)` bits. It counts `FRAME_LEN-1` down to 0, where `FRAME_LEN` = `WIDTH`, or `WIDTH+1` with parity. Last bit cycle ⇔ counter==0 in `SHIFT`.
- `done` = (state==`SHIFT`) && counter==0.
- `in_valid` while `in_ready`=0 is ignored. The sender must hold it; the word is not lost and is not sampled early.
- Reset values: `serial_out`=0, `serial_en`=0, `done`=0, `in_ready`=1, state `IDLE`, counter 0, `shreg` 0.
- Reset mid-word: the frame aborts immediately on assertion. Outputs go to reset values, no `done` is issued, and the partial word is discarded.

## Timing
- Latency: accept at edge N gives the first bit on `serial_out` with `serial_en`=1 in cycle N..N+1.
- A frame occupies exactly `FRAME_LEN` consecutive cycles with `serial_en`=1.
- Back-to-back: accept on the last bit cycle gives zero idle cycles between frames, and `serial_en` stays high continuously.
- Receiver alignment: a `sipo_shift_reg` fed from this block holds the complete word on the edge that ends the `done` cycle.
- Outputs `serial_out`, `serial_en` and `done` are registered state or decodes of registered state. No input-to-output combinational path exists.

## Configuration
- Macro: `PISO_SERIALIZER_PARITY_EN`.
- Defined:
  - `FRAME_LEN`=`WIDTH+1`.
  - After the data bits, one even-parity bit (XOR of the accepted word) is sent with `serial_en`=1.
  - `done` marks the parity cycle.
  - Parity is computed at accept time and stored in a 1-bit register that resets to 0.
- Undefined: `FRAME_LEN`=`WIDTH`, and no parity logic is present.

## Structure
- Package `piso_pkg`:
  - FSM state enum `{IDLE, SHIFT}`.
  - `FRAME_LEN` computation, expressed as a function of `WIDTH` and the macro.
- Sub-module `piso_bit_counter`: loadable down-counter with a `zero` flag. It is parameterized by load value width.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles, then release with `in_valid`=0 → `in_ready`=1, `serial_en`=0, `serial_out`=0, `done`=0 for 10 cycles.
- Single word, `WIDTH`=4, `MSB_FIRST`=1: send 4'b1011 → `serial_out` is 1,0,1,1 on 4 consecutive cycles with `serial_en`=1, and `done` is high on the 4th. A SIPO in loopback then shows `parallel_out`=4'b1011.
- Back-to-back: 4'b1100 then 4'b0110, with `in_valid` held → 8 contiguous `serial_en` cycles with bits 1,1,0,0,0,1,1,0. `in_ready` is high only on cycles 4 and 8 of the stream.
- LSB-first, `MSB_FIRST`=0: send 4'b1000 → bits 0,0,0,1.
- Reset mid-word: assert `rst_n` on the 2nd bit of 4'b1111 → next sample shows `serial_en`=0, no `done`, `in_ready`=1. A new word 4'b0101 then transmits correctly.
- Parity (macro defined): send 4'b0111 → bits 0,1,1,1, then parity 1, over 5 cycles with `done` on the 5th. Sending 4'b0000 gives parity bit 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and frame geometry for the PISO serializer.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN (appends one even-parity bit per frame).
package piso_pkg;

  // Controller states: waiting for a word, or presenting bits of a frame.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Number of serial cycles one accepted word occupies on the link.
  function automatic int frame_len(input int width);
`ifdef PISO_SERIALIZER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count;

  // Load has priority so a back-to-back accept on the last bit restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding a sipo_shift_reg receiver.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN (even-parity bit after the data bits).
//
// Handshake: a word is taken on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state, never on in_valid; a sender
// that sees in_ready low must keep in_valid and parallel_in stable.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_en,
  output logic             done
);

  localparam int            FRAME_LEN = frame_len(WIDTH);
  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LOAD_VAL  = CW'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic             cnt_zero;
  logic             accept;
  logic             data_bit;

  assign accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; the last bit cycle doubles as an accept slot.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    serial_en  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        serial_en = 1'b1;
        if (cnt_zero) begin
          done     = 1'b1;
          in_ready = 1'b1;
          if (!in_valid) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  piso_bit_counter #(
    .CW (CW)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (LOAD_VAL),
    .dec      (serial_en),
    .zero     (cnt_zero)
  );

  // Shift direction selects which end of the register is on the wire.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
      data_bit      = shreg[WIDTH-1];
    end else begin
      shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
      data_bit      = shreg[0];
    end
  end

  // Capture the word on accept, otherwise advance one bit per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= parallel_in;
    end else if (serial_en) begin
      shreg <= shreg_shifted;
    end
  end

`ifdef PISO_SERIALIZER_PARITY_EN
  logic par_q;

  // Parity is fixed at accept time so the shifting register needs no extra bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^parallel_in;
    end
  end

  // Counter reaching zero marks the trailing parity cycle.
  assign serial_out = serial_en && (cnt_zero ? par_q : data_bit);
`else
  assign serial_out = serial_en && data_bit;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: two instances (MSB-first and
// LSB-first), a queue-based reference of the serial stream, and a
// behavioural receiver on the MSB-first link.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         v_m = 1'b0, v_l = 1'b0;
  logic [W-1:0] d_m = '0, d_l = '0;
  logic         rdy_m, so_m, se_m, dn_m;
  logic         rdy_l, so_l, se_l, dn_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (v_m),
    .in_ready    (rdy_m),
    .parallel_in (d_m),
    .serial_out  (so_m),
    .serial_en   (se_m),
    .done        (dn_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (v_l),
    .in_ready    (rdy_l),
    .parallel_in (d_l),
    .serial_out  (so_l),
    .serial_en   (se_l),
    .done        (dn_l)
  );

  // Receiver model: left-shifting SIPO clocked by serial_en.
  logic [FL-1:0] sipo;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sipo <= '0;
    else if (se_m) sipo <= {sipo[FL-2:0], so_m};
  end

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  logic         exp_q[$];
  logic         exp_done_q[$];
  logic [W-1:0] exp_q_word[$];
  logic [W-1:0] words_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit sel, input logic v, input logic [W-1:0] d);
    if (sel) begin
      v_l = v; d_l = d;
    end else begin
      v_m = v; d_m = d;
    end
  endtask

  // Sends words_q back-to-back on one instance (sel 0 = MSB-first, 1 = LSB-first)
  // and checks every cycle against the expected bit stream. Entered and left
  // just after a rising edge.
  task automatic send_stream(input bit sel);
    int           idx, cyc, gaps, pos;
    bit           started, acc, pending, b, dexp, vcur;
    logic         so, se, dn, rdy;
    logic [W-1:0] w;
    exp_q.delete(); exp_done_q.delete(); exp_q_word.delete();
    foreach (words_q[k]) begin
      w = words_q[k];
      for (int i = 0; i < W; i++) exp_q.push_back(sel ? w[i] : w[W-1-i]);
`ifdef PISO_SERIALIZER_PARITY_EN
      exp_q.push_back(^w);
`endif
      for (int i = 0; i < FL; i++) exp_done_q.push_back(i == FL - 1);
      exp_q_word.push_back(w);
    end
    idx = 0; cyc = 0; gaps = 0; pos = 0;
    started = 0; pending = 0;
    drive(sel, 1'b1, words_q[0]);
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      so   = sel ? so_l : so_m;
      se   = sel ? se_l : se_m;
      dn   = sel ? dn_l : dn_m;
      rdy  = sel ? rdy_l : rdy_m;
      vcur = sel ? v_l : v_m;
      if (se) begin
        b    = exp_q.pop_front();
        dexp = exp_done_q.pop_front();
        check($sformatf("bit[%0d]", pos), so, b);
        check($sformatf("done[%0d]", pos), dn, dexp);
        check($sformatf("ready_busy[%0d]", pos), rdy, dexp);
        if (dexp && !sel) pending = 1;
        pos++;
      end else begin
        check("done_idle", dn, 0);
        check("so_idle", so, 0);
        check("ready_idle", rdy, 1);
        if (started) gaps++;
      end
      acc = rdy && vcur;
      @(posedge clk); #1;
      if (pending) begin
        check("sipo_word", sipo[FL-1 -: W], exp_q_word.pop_front());
        pending = 0;
      end
      if (acc) begin
        started = 1;
        idx++;
        if (idx < words_q.size()) drive(sel, 1'b1, words_q[idx]);
        else drive(sel, 1'b0, '0);
      end
      cyc++;
    end
    drive(sel, 1'b0, '0);
    check("stream_drained", exp_q.size(), 0);
    check("no_gaps", gaps, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset held for two cycles.
    @(negedge clk);
    check("rst_ready", rdy_m, 1);
    check("rst_en", se_m, 0);
    check("rst_so", so_m, 0);
    check("rst_done", dn_m, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle with no valid.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", rdy_m, 1);
      check("idle_en", se_m, 0);
      check("idle_so", so_m, 0);
      check("idle_done", dn_m, 0);
    end
    @(posedge clk); #1;

    // Single word, MSB first.
    words_q.delete(); words_q.push_back(4'b1011);
    send_stream(0);
    @(posedge clk); #1;

    // Back-to-back pair with valid held.
    words_q.delete(); words_q.push_back(4'b1100); words_q.push_back(4'b0110);
    send_stream(0);
    @(posedge clk); #1;

    // LSB first.
    words_q.delete(); words_q.push_back(4'b1000);
    send_stream(1);
    @(posedge clk); #1;

    // Reset asserted during the second bit of 4'b1111.
    drive(0, 1'b1, 4'b1111);
    @(posedge clk); #1;
    drive(0, 1'b0, '0);
    @(posedge clk);
    @(negedge clk);
    check("mid_bit2_en", se_m, 1);
    check("mid_bit2_so", so_m, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_en", se_m, 0);
    check("abort_done", dn_m, 0);
    check("abort_ready", rdy_m, 1);
    check("abort_so", so_m, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_en", se_m, 0);
      check("post_abort_done", dn_m, 0);
    end
    @(posedge clk); #1;
    words_q.delete(); words_q.push_back(4'b0101);
    send_stream(0);
    @(posedge clk); #1;

    // Parity-specific words (parity bit is checked only when the feature is built in).
    words_q.delete(); words_q.push_back(4'b0111); words_q.push_back(4'b0000);
    send_stream(0);
    @(posedge clk); #1;

    // Random streams on either instance with random idle gaps.
    for (int r = 0; r < 20; r++) begin
      int n;
      bit s;
      n = $urandom_range(1, 4);
      s = 1'($urandom_range(0, 1));
      words_q.delete();
      for (int k = 0; k < n; k++) words_q.push_back(W'($urandom));
      send_stream(s);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
